digit_rev_addr_gen: RTL

//  Sequential address generator for an N = R0*R1 point mixed-radix FFT buffer.

---
 rtl/digit_rev_pkg.sv | 29 ++
 rtl/digit_rev_addr_gen_mod_acc.sv | 45 ++++
 rtl/digit_rev_addr_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/digit_rev_pkg.sv
// Shared types and helpers for the mixed-radix digit-reversal address generator.
// The DIGIT_REV_CRT_MAP_EN macro enables the Good-Thomas CRT order (mode 2).
package digit_rev_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_NAT = 2'd0;
    localparam logic [1:0] MODE_REV = 2'd1;
    localparam logic [1:0] MODE_CRT = 2'd2;

    // Euclid's algorithm; only evaluated at elaboration for the coprime check.
    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

endpackage

// File: rtl/digit_rev_addr_gen_mod_acc.sv
// Registered accumulator: clear, load, or add STEP. With WRAP set the sum wraps mod N;
// without it a plain adder is built (callers guarantee no overflow past N-1).
module mod_acc #(
    parameter int N    = 15,
    parameter int STEP = 3,
    parameter int AW   = $clog2(N),
    parameter bit WRAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] acc
);

    logic [AW-1:0] nxt;

    generate
        if (WRAP) begin : g_wrap
            // One extra bit so acc+STEP cannot overflow before the compare.
            logic [AW:0] sum;
            always_comb begin
                sum = {1'b0, acc} + (AW+1)'(STEP);
                nxt = (sum >= (AW+1)'(N)) ? AW'(sum - (AW+1)'(N)) : AW'(sum);
            end
        end else begin : g_plain
            always_comb nxt = acc + AW'(STEP);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (step) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/digit_rev_addr_gen.sv
// Sequential natural/mapped address generator for an R0*R1 mixed-radix FFT buffer.
// Define DIGIT_REV_CRT_MAP_EN to add the Good-Thomas CRT map as mode 2.
module digit_rev_addr_gen
    import digit_rev_pkg::*;
#(
    parameter int R0 = 3,
    parameter int R1 = 5,
    parameter int AW = $clog2(R0*R1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          abort,
    input  logic          ready,
    output logic          valid,
    output logic [AW-1:0] nat_addr,
    output logic [AW-1:0] out_addr,
    output logic          last,
    output logic          busy
);

    localparam int N = R0 * R1;
    localparam logic [AW-1:0] D0_MAX = AW'(R0 - 1);
    localparam logic [AW-1:0] D1_MAX = AW'(R1 - 1);

    generate
        if (R0 < 2 || R1 < 2) begin : g_bad_radix
            $error("digit_rev_addr_gen: R0 and R1 must both be >= 2");
        end
        if (AW != $clog2(R0*R1)) begin : g_bad_aw
            $error("digit_rev_addr_gen: AW is derived from R0*R1 and must not be overridden");
        end
`ifdef DIGIT_REV_CRT_MAP_EN
        if (gcd(R0, R1) != 1) begin : g_bad_gcd
            $error("digit_rev_addr_gen: CRT map needs coprime R0 and R1");
        end
`endif
    endgenerate

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    mode_q;
    logic [AW-1:0] d0;
    logic [AW-1:0] d1;
    logic [AW-1:0] nat_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_load_val;
    logic          accept;
    logic          d1_wrap;
    logic          clear;
    logic          sel_nat;

    // Handshake: a beat transfers on a cycle with valid & ready; while valid & !ready every
    // output holds. valid never depends on ready, and abort overrides a same-cycle transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (abort || (accept && last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == RUN);
        busy  = (state == RUN);
        last  = valid && (d0 == D0_MAX) && (d1 == D1_MAX);
    end

    assign accept  = valid && ready;
    assign d1_wrap = (d1 == D1_MAX);
    // Counters sit at zero whenever no sweep is in flight, so a start always begins at n=0.
    assign clear   = (state != RUN) || abort || (accept && last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0    <= '0;
            d1    <= '0;
            nat_q <= '0;
        end else if (clear) begin
            d0    <= '0;
            d1    <= '0;
            nat_q <= '0;
        end else if (accept) begin
            nat_q <= nat_q + AW'(1);
            if (d1_wrap) begin
                d1 <= '0;
                d0 <= d0 + AW'(1);
            end else begin
                d1 <= d1 + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_NAT;
        end else if (state == IDLE && start) begin
            mode_q <= mode;
        end
    end

`ifdef DIGIT_REV_CRT_MAP_EN
    localparam bit ACC_WRAP = 1'b1;
    logic [AW-1:0] row_base;
    logic          sel_crt;

    // row_base tracks R1*d0, which stays below N for every row that can still wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_base <= '0;
        end else if (clear) begin
            row_base <= '0;
        end else if (accept && d1_wrap) begin
            row_base <= row_base + AW'(R1);
        end
    end

    always_comb begin
        sel_crt      = (mode_q == MODE_CRT);
        sel_nat      = (mode_q == MODE_NAT);
        acc_load_val = sel_crt ? (row_base + AW'(R1)) : (d0 + AW'(1));
    end
`else
    localparam bit ACC_WRAP = 1'b0;

    // Without the CRT map, mode 2 aliases natural order and mode 3 aliases reversed order.
    always_comb begin
        sel_nat      = (mode_q == MODE_NAT) || (mode_q == MODE_CRT);
        acc_load_val = d0 + AW'(1);
    end
`endif

    mod_acc #(
        .N   (N),
        .STEP(R0),
        .AW  (AW),
        .WRAP(ACC_WRAP)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .load    (accept && d1_wrap),
        .step    (accept && !d1_wrap),
        .load_val(acc_load_val),
        .acc     (acc_q)
    );

    assign nat_addr = nat_q;
    assign out_addr = sel_nat ? nat_q : acc_q;

endmodule
